// File: rtl/dsp_mult_checker_pkg.sv
// dsp_mult_checker_pkg
// Shared types and constants for the DSP48E1 multiplier checker:
//   - run-sequencer state enum
//   - operand, product and DSP port widths
//   - the four corner operands issued ahead of the random vectors
//   - LFSR tap masks (Fibonacci, feedback = XOR of the masked bits)
//   - mult_sx(): fabric reference product, signed 25x18 sign-extended to 48
package dsp_mult_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int A_W     = 25;
  localparam int B_W     = 18;
  localparam int PROD_W  = 43;
  localparam int P_W     = 48;
  localparam int DSP_A_W = 30;
  localparam int DSP_B_W = 18;
  localparam int DSP_P_W = 48;

  localparam logic [A_W-1:0] CORNER_A_MAX = 25'h0FF_FFFF;  // +16777215
  localparam logic [A_W-1:0] CORNER_A_MIN = 25'h100_0000;  // -16777216
  localparam logic [B_W-1:0] CORNER_B_MAX = 18'h1_FFFF;    // +131071
  localparam logic [B_W-1:0] CORNER_B_MIN = 18'h2_0000;    // -131072

  // x^25 + x^22 + 1 -> state bits 24 and 21
  localparam logic [A_W-1:0] LFSR_A_TAPS = 25'h120_0000;
  // x^18 + x^11 + 1 -> state bits 17 and 10
  localparam logic [B_W-1:0] LFSR_B_TAPS = 18'h2_0400;

  function automatic logic [P_W-1:0] mult_sx(input logic signed [A_W-1:0] a,
                                             input logic signed [B_W-1:0] b);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(b);
    return {{(P_W-PROD_W){prod[PROD_W-1]}}, prod};
  endfunction

endpackage

// File: rtl/dsp_mult_checker_lfsr_gen.sv
// lfsr_gen
// Fibonacci LFSR shifting towards the MSB; the feedback bit is the XOR of
// the state bits selected by TAPS and enters at bit 0.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (state -> SEED)
//   load_i      - reload SEED (has priority over advance_i)
//   advance_i   - step the register once
//   value_o     - current state
// SEED must be nonzero; the all-zero state is a lock-up state and is never
// reachable from a nonzero seed.
module lfsr_gen #(
  parameter int unsigned         WIDTH = 25,
  parameter logic [WIDTH-1:0]    TAPS  = '1,
  parameter logic [WIDTH-1:0]    SEED  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (advance_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q;

endmodule

// File: rtl/dsp_mult_checker.sv
// dsp_mult_checker
// Stimulus source and result checker for one DSP48E1 used as a fully
// registered signed 25x18 multiplier. Issues NUM_VECTORS operand pairs
// (four corners, then LFSR-generated values), predicts each product in
// fabric, and compares it with dsp_p LATENCY+1 edges after issue.
//
// State | meaning
// IDLE  | waiting for enable; results of the previous run held
// RUN   | one vector issued per cycle
// DRAIN | issuing stopped, waiting for the last compares
// DONE  | all vectors checked; held until enable falls
//
// Ports:
//   clk, rst_n  - DSP clock, asynchronous active-low reset
//   enable      - run gate (PLL locked); dropping it mid-run aborts
//   dsp_a/dsp_b - registered operands to the DSP (A sign-extended to 30)
//   dsp_p       - DSP product
//   busy, done  - run in progress / all vectors checked
//   fail, pass  - sticky mismatch flag / done with no mismatch
//   err_count   - saturating mismatch count
//
// Build option: define DSP_MULT_CHECKER_ERR_INJECT_EN to invert bit 0 of the
// expected value for vector 2, so a healthy DSP reports exactly one error.
module dsp_mult_checker
  import dsp_mult_checker_pkg::*;
#(
  parameter int             NUM_VECTORS = 1024,
  parameter int             LATENCY     = 3,
  parameter logic [A_W-1:0] SEED_A      = 25'h0ACE1,
  parameter logic [B_W-1:0] SEED_B      = 18'h1F00D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [DSP_A_W-1:0] dsp_a,
  output logic [DSP_B_W-1:0] dsp_b,
  input  logic [DSP_P_W-1:0] dsp_p,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               pass,
  output logic [15:0]        err_count
);

  localparam int IDX_W = $clog2(NUM_VECTORS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DSP_A_W-1:0]   dsp_a_q;
  logic [DSP_B_W-1:0]   dsp_b_q;
  // Issue register: travels with dsp_a_q/dsp_b_q, then LATENCY more stages
  // bring the expectation level with dsp_p on the compare edge.
  logic                 iss_vld_q;
  logic [P_W-1:0]       iss_exp_q;
  logic [LATENCY-1:0]   vld_pipe_q;
  logic [P_W-1:0]       exp_pipe_q [LATENCY];
  logic [15:0]          err_q;
  logic                 fail_q;
  logic                 busy_q;
  logic                 done_q;

  logic [A_W-1:0]       a_lfsr;
  logic [B_W-1:0]       b_lfsr;
  logic                 lfsr_load;
  logic                 lfsr_adv;
  logic [A_W-1:0]       vec_a;
  logic [B_W-1:0]       vec_b;
  logic [P_W-1:0]       vec_exp;
  logic                 cmp_err;
  logic                 pipe_empty;

  assign lfsr_load = (state_q == ST_IDLE) && enable;
  assign lfsr_adv  = (state_q == ST_RUN) && enable && (idx_q >= IDX_W'(4));

  lfsr_gen #(
    .WIDTH (A_W),
    .TAPS  (LFSR_A_TAPS),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (lfsr_load),
    .advance_i (lfsr_adv),
    .value_o   (a_lfsr)
  );

  lfsr_gen #(
    .WIDTH (B_W),
    .TAPS  (LFSR_B_TAPS),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (lfsr_load),
    .advance_i (lfsr_adv),
    .value_o   (b_lfsr)
  );

  always_comb begin
    vec_a = a_lfsr;
    vec_b = b_lfsr;
    if (idx_q == IDX_W'(0)) begin
      vec_a = '0;
      vec_b = '0;
    end else if (idx_q == IDX_W'(1)) begin
      vec_a = CORNER_A_MAX;
      vec_b = CORNER_B_MAX;
    end else if (idx_q == IDX_W'(2)) begin
      vec_a = CORNER_A_MIN;
      vec_b = CORNER_B_MIN;
    end else if (idx_q == IDX_W'(3)) begin
      vec_a = CORNER_A_MIN;
      vec_b = CORNER_B_MAX;
    end
    vec_exp = mult_sx(vec_a, vec_b);
`ifdef DSP_MULT_CHECKER_ERR_INJECT_EN
    if (idx_q == IDX_W'(2)) begin
      vec_exp[0] = ~vec_exp[0];
    end
`endif
  end

  assign cmp_err    = vld_pipe_q[LATENCY-1] && (dsp_p != exp_pipe_q[LATENCY-1]);
  assign pipe_empty = !iss_vld_q && (vld_pipe_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      dsp_a_q    <= '0;
      dsp_b_q    <= '0;
      iss_vld_q  <= 1'b0;
      iss_exp_q  <= '0;
      vld_pipe_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_pipe_q[i] <= '0;
      end
      err_q      <= '0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (!enable) begin
            // Abort: drop everything in flight, keep the error record.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            iss_vld_q  <= 1'b0;
            vld_pipe_q <= '0;
          end else begin
            vld_pipe_q[0] <= iss_vld_q;
            exp_pipe_q[0] <= iss_exp_q;
            for (int i = 1; i < LATENCY; i++) begin
              vld_pipe_q[i] <= vld_pipe_q[i-1];
              exp_pipe_q[i] <= exp_pipe_q[i-1];
            end

            if (cmp_err) begin
              fail_q <= 1'b1;
              if (err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
              end
            end

            if (state_q == ST_RUN) begin
              dsp_a_q   <= {{(DSP_A_W-A_W){vec_a[A_W-1]}}, vec_a};
              dsp_b_q   <= vec_b;
              iss_vld_q <= 1'b1;
              iss_exp_q <= vec_exp;
              idx_q     <= idx_q + IDX_W'(1);
              if (idx_q == LAST_IDX) begin
                state_q <= ST_DRAIN;
              end
            end else begin
              iss_vld_q <= 1'b0;
              if (pipe_empty) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dsp_a     = dsp_a_q;
  assign dsp_b     = dsp_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign pass      = done_q & ~fail_q;
  assign err_count = err_q;

endmodule
